// File: rtl/apb_fifo_s.sv
`default_nettype none
// ============================================================================
//  Module   : apb_fifo_s
//  Brief    : APB3 slave exposing a 32-bit word FIFO through four registers
//             (DATA, STATUS, CONTROL, reserved), with programmable wait
//             states, PSLVERR on illegal accesses and a fill-level IRQ.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_fifo_s #(
    parameter int P_DEPTH = 16,  // FIFO depth in words, power of 2, 2..128
    parameter int P_DELAY = 0    // wait states per access phase, 0..15
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ
);

    localparam int         c_AW    = $clog2(P_DEPTH);
    localparam int         c_CW    = c_AW + 1;
    localparam logic [3:0] c_DELAY = 4'(P_DELAY);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(P_DEPTH);

    // Storage and state
    logic [31:0]     r_mem [0:P_DEPTH-1];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic            r_unf;
    logic            r_err_en;
    logic [7:0]      r_thresh;
    logic [3:0]      r_wcnt;
    logic            r_irq;

    // Transfer handshake
    logic w_access;
    logic w_ready;
    logic w_comp;

    // Decoded side effects of the completing cycle
    logic        w_push;
    logic        w_pop;
    logic        w_ovf_set;
    logic        w_unf_set;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic [31:0] w_prdata;
    logic        w_pslverr;

    logic            w_full;
    logic            w_empty;
    logic [31:0]     w_status;
    logic [31:0]     w_control;
    logic [c_CW-1:0] w_count_next;
    logic [7:0]      w_count8_next;
    logic [7:0]      w_thresh_next;

    // Only PADDR[3:2] selects a register; the rest is intentionally ignored
    logic w_unused_addr;
    assign w_unused_addr = ^{PADDR[31:4], PADDR[1:0]};

    assign w_access = PSEL & PENABLE;
    assign w_ready  = !w_access || (r_wcnt == c_DELAY);
    assign w_comp   = w_access & w_ready;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    assign w_status  = {16'h0000, 8'(r_count), 4'h0, r_unf, r_ovf, w_full, w_empty};
    assign w_control = {16'h0000, r_thresh, 6'h00, r_err_en, 1'b0};

    // Register decode: response and side-effect strobes, only in the completing cycle
    always_comb begin
        w_prdata  = 32'h0;
        w_pslverr = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        w_ctrl_wr = 1'b0;
        w_flush   = 1'b0;
        if (w_comp) begin
            case (PADDR[3:2])
                2'd0: begin
                    if (PWRITE) begin
                        if (w_full) begin
                            w_ovf_set = 1'b1;
                            w_pslverr = r_err_en;
                        end else begin
                            w_push = 1'b1;
                        end
                    end else begin
                        if (w_empty) begin
                            w_unf_set = 1'b1;
                            w_pslverr = r_err_en;
                        end else begin
                            w_prdata = r_mem[r_rptr];
                            w_pop    = 1'b1;
                        end
                    end
                end
                2'd1: begin
                    if (PWRITE) begin
                        w_pslverr = 1'b1;
                    end else begin
                        w_prdata = w_status;
                    end
                end
                2'd2: begin
                    if (PWRITE) begin
                        w_ctrl_wr = 1'b1;
                        w_flush   = PWDATA[0];
                    end else begin
                        w_prdata = w_control;
                    end
                end
                default: begin
                    w_pslverr = 1'b1;
                end
            endcase
        end
    end

    // Next fill level and threshold, shared by the count register and the IRQ
    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push) begin
            w_count_next = r_count + c_CW'(1);
        end else if (w_pop) begin
            w_count_next = r_count - c_CW'(1);
        end
        w_count8_next = 8'(w_count_next);
        w_thresh_next = w_ctrl_wr ? PWDATA[15:8] : r_thresh;
    end

    // FIFO data array; no reset needed since count gates every read
    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= PWDATA;
        end
    end

    // Control state: wait counter, pointers, flags, CONTROL fields and IRQ
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wcnt   <= 4'h0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_err_en <= 1'b0;
            r_thresh <= 8'h00;
            r_irq    <= 1'b0;
        end else begin
            // Dropping PSEL or completing restarts the wait count
            if (!w_access || w_comp) begin
                r_wcnt <= 4'h0;
            end else if (r_wcnt < c_DELAY) begin
                r_wcnt <= r_wcnt + 4'h1;
            end

            r_count <= w_count_next;

            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_ovf  <= 1'b0;
                r_unf  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_AW'(1);
                end
                if (w_ovf_set) begin
                    r_ovf <= 1'b1;
                end
                if (w_unf_set) begin
                    r_unf <= 1'b1;
                end
            end

            if (w_ctrl_wr) begin
                r_err_en <= PWDATA[1];
                r_thresh <= PWDATA[15:8];
            end

            // IRQ tracks the post-edge count so it moves together with STATUS
            r_irq <= (w_thresh_next != 8'h00) && (w_count8_next >= w_thresh_next);
        end
    end

    assign PRDATA  = w_prdata;
    assign PREADY  = w_ready;
    assign PSLVERR = w_pslverr;
    assign IRQ     = r_irq;

endmodule
`default_nettype wire
